// File: rtl/frv_asi_seq.sv
// +----------------------------------------------------------------------------+
// | frv_asi_seq: request/response sequencer in front of the AES/SHA2/SHA3 ASI  |
// | unit, with serialised AES state flushes. Optional busy timeout: define     |
// | FRV_ASI_SEQ_TIMEOUT_EN.                                                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module frv_asi_seq #(
  parameter int XLEN  = 32,
  parameter int UOP_W = 7
`ifdef FRV_ASI_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [UOP_W-1:0] req_uop,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [1:0]       req_shamt,
  input  logic             kill,
  input  logic             flush_req,
  input  logic             flush_sub,
  input  logic             flush_mix,
  input  logic [XLEN-1:0]  flush_data,
  output logic             flush_ack,
  output logic             asi_valid,
  output logic [UOP_W-1:0] asi_uop,
  output logic [XLEN-1:0]  asi_rs1,
  output logic [XLEN-1:0]  asi_rs2,
  output logic [1:0]       asi_shamt,
  input  logic             asi_ready,
  input  logic [XLEN-1:0]  asi_result,
  output logic             asi_flush_aessub,
  output logic             asi_flush_aesmix,
  output logic [XLEN-1:0]  asi_flush_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_result,
  output logic             rsp_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [UOP_W-1:0] uop_q;
  logic [XLEN-1:0]  rs1_q, rs2_q, result_q, fdata_q;
  logic [1:0]       shamt_q;
  logic             fsub_q, fmix_q;
  logic             w_flush_go, w_accept, w_done;

  // A pending flush beats a request presented in the same cycle.
  assign w_flush_go = (state_q == S_IDLE) && flush_req && !kill;
  assign w_accept   = (state_q == S_IDLE) && !flush_req && req_valid && !kill;
  assign w_done     = (state_q == S_BUSY) && !kill && asi_ready;

`ifdef FRV_ASI_SEQ_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;
  logic       w_timeout;

  assign w_timeout = (state_q == S_BUSY) && !kill && !asi_ready &&
                     (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      if (w_accept)
        cnt_q <= 8'd0;
      else if (state_q == S_BUSY && !asi_ready)
        cnt_q <= cnt_q + 8'd1;
      if (w_done)
        err_q <= 1'b0;
      else if (w_timeout)
        err_q <= 1'b1;
    end
  end
`else
  logic w_timeout;
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_flush_go) state_d = S_FLUSH;
               else if (w_accept) state_d = S_BUSY;
      S_BUSY:  if (kill) state_d = S_IDLE;
               else if (asi_ready || w_timeout) state_d = S_RESP;
      S_RESP:  if (kill || rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      uop_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      shamt_q  <= '0;
      result_q <= '0;
      fsub_q   <= 1'b0;
      fmix_q   <= 1'b0;
      fdata_q  <= '0;
    end else begin
      if (w_accept) begin
        uop_q   <= req_uop;
        rs1_q   <= req_rs1;
        rs2_q   <= req_rs2;
        shamt_q <= req_shamt;
      end
      if (w_flush_go) begin
        fsub_q  <= flush_sub;
        fmix_q  <= flush_mix;
        fdata_q <= flush_data;
      end
      if (w_done)
        result_q <= asi_result;
      else if (w_timeout)
        result_q <= '0;
    end
  end

  // Unit-facing operands are gated to zero whenever no operation is offered.
  always_comb begin
    req_ready        = w_accept;
    asi_valid        = (state_q == S_BUSY);
    asi_uop          = asi_valid ? uop_q   : '0;
    asi_rs1          = asi_valid ? rs1_q   : '0;
    asi_rs2          = asi_valid ? rs2_q   : '0;
    asi_shamt        = asi_valid ? shamt_q : '0;
    flush_ack        = (state_q == S_FLUSH);
    asi_flush_aessub = flush_ack && fsub_q;
    asi_flush_aesmix = flush_ack && fmix_q;
    asi_flush_data   = flush_ack ? fdata_q : '0;
    rsp_valid        = (state_q == S_RESP);
    rsp_result       = rsp_valid ? result_q : '0;
`ifdef FRV_ASI_SEQ_TIMEOUT_EN
    rsp_err          = rsp_valid && err_q;
`else
    rsp_err          = 1'b0;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_frv_asi_seq.sv
// +----------------------------------------------------------------------------+
// | tb_frv_asi_seq: directed scenarios plus random traffic for frv_asi_seq,    |
// | checked cycle by cycle against a transaction-level reference model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_frv_asi_seq;

  localparam int XLEN    = 32;
  localparam int UOP_W   = 7;
  localparam int TIMEOUT = 15;

  logic             g_clk, g_resetn;
  logic             req_valid, req_ready;
  logic [UOP_W-1:0] req_uop;
  logic [XLEN-1:0]  req_rs1, req_rs2;
  logic [1:0]       req_shamt;
  logic             kill, flush_req, flush_sub, flush_mix, flush_ack;
  logic [XLEN-1:0]  flush_data;
  logic             asi_valid;
  logic [UOP_W-1:0] asi_uop;
  logic [XLEN-1:0]  asi_rs1, asi_rs2;
  logic [1:0]       asi_shamt;
  logic             asi_ready;
  logic [XLEN-1:0]  asi_result;
  logic             asi_flush_aessub, asi_flush_aesmix;
  logic [XLEN-1:0]  asi_flush_data;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [XLEN-1:0]  rsp_result;

  frv_asi_seq u_dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_uop(req_uop),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_shamt(req_shamt),
    .kill(kill), .flush_req(flush_req), .flush_sub(flush_sub),
    .flush_mix(flush_mix), .flush_data(flush_data), .flush_ack(flush_ack),
    .asi_valid(asi_valid), .asi_uop(asi_uop), .asi_rs1(asi_rs1),
    .asi_rs2(asi_rs2), .asi_shamt(asi_shamt), .asi_ready(asi_ready),
    .asi_result(asi_result), .asi_flush_aessub(asi_flush_aessub),
    .asi_flush_aesmix(asi_flush_aesmix), .asi_flush_data(asi_flush_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_err(rsp_err)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: what the sequencer currently owes each side.
  bit               m_op_pending;   // operation offered to the unit
  bit               m_rsp_pending;  // result waiting for the consumer
  bit               m_flush_now;    // flush being issued this cycle
  logic [UOP_W-1:0] m_uop;
  logic [XLEN-1:0]  m_rs1, m_rs2, m_res, m_fdata;
  logic [1:0]       m_shamt;
  bit               m_err, m_fsub, m_fmix;
  int               m_waited;

  task automatic model_reset();
    m_op_pending = 0; m_rsp_pending = 0; m_flush_now = 0;
    m_uop = '0; m_rs1 = '0; m_rs2 = '0; m_res = '0; m_fdata = '0;
    m_shamt = '0; m_err = 0; m_fsub = 0; m_fmix = 0; m_waited = 0;
  endtask

  function automatic bit m_idle();
    return !(m_op_pending || m_rsp_pending || m_flush_now);
  endfunction

  task automatic check_outputs();
    chk("req_ready", req_ready, m_idle() && req_valid && !kill && !flush_req);
    chk("asi_valid", asi_valid, m_op_pending);
    chk("asi_uop",   asi_uop,   m_op_pending ? m_uop   : '0);
    chk("asi_rs1",   asi_rs1,   m_op_pending ? m_rs1   : '0);
    chk("asi_rs2",   asi_rs2,   m_op_pending ? m_rs2   : '0);
    chk("asi_shamt", asi_shamt, m_op_pending ? m_shamt : '0);
    chk("flush_ack", flush_ack, m_flush_now);
    chk("flush_sub", asi_flush_aessub, m_flush_now && m_fsub);
    chk("flush_mix", asi_flush_aesmix, m_flush_now && m_fmix);
    chk("flush_dat", asi_flush_data, m_flush_now ? m_fdata : '0);
    chk("rsp_valid", rsp_valid, m_rsp_pending);
    chk("rsp_res",   rsp_result, m_rsp_pending ? m_res : '0);
    chk("rsp_err",   rsp_err,    m_rsp_pending && m_err);
  endtask

  task automatic model_next();
    if (m_flush_now) begin
      m_flush_now = 0;
    end else if (m_idle()) begin
      if (flush_req && !kill) begin
        m_flush_now = 1; m_fsub = flush_sub; m_fmix = flush_mix; m_fdata = flush_data;
      end else if (req_valid && !kill) begin
        m_op_pending = 1; m_waited = 0;
        m_uop = req_uop; m_rs1 = req_rs1; m_rs2 = req_rs2; m_shamt = req_shamt;
      end
    end else if (m_op_pending) begin
      m_waited++;
      if (kill) begin
        m_op_pending = 0;
      end else if (asi_ready) begin
        m_op_pending = 0; m_rsp_pending = 1; m_res = asi_result; m_err = 0;
      end
`ifdef FRV_ASI_SEQ_TIMEOUT_EN
      else if (m_waited == TIMEOUT) begin
        m_op_pending = 0; m_rsp_pending = 1; m_res = '0; m_err = 1;
      end
`endif
    end else if (m_rsp_pending) begin
      if (kill || rsp_ready) m_rsp_pending = 0;
    end
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic step();
    #1;
    check_outputs();
    model_next();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_uop = '0; req_rs1 = '0; req_rs2 = '0; req_shamt = '0;
    kill = 0; flush_req = 0; flush_sub = 0; flush_mix = 0; flush_data = '0;
    asi_ready = 0; asi_result = '0; rsp_ready = 0;
  endtask

  task automatic rand_inputs();
    req_valid  = ($urandom_range(1) == 1);
    req_uop    = UOP_W'($urandom);
    req_rs1    = $urandom;
    req_rs2    = $urandom;
    req_shamt  = 2'($urandom);
    kill       = ($urandom_range(15) == 0);
    flush_req  = ($urandom_range(5) == 0);
    flush_sub  = ($urandom_range(1) == 1);
    flush_mix  = ($urandom_range(1) == 1);
    flush_data = $urandom;
    asi_ready  = ($urandom_range(3) == 0);
    asi_result = $urandom;
    rsp_ready  = ($urandom_range(1) == 1);
  endtask

  int n;

  initial begin
    idle_inputs();
    model_reset();
    g_resetn = 0;
    repeat (2) @(posedge g_clk);
    #1;
    check_outputs();
    g_resetn = 1;

    // SHA2-style op: accept c0, ready c1, response c2.
    req_valid = 1; req_uop = 7'h21; req_rs1 = 32'h1111_0000; req_rs2 = 32'h0000_2222;
    #1 chk("t1_accept", req_ready, 1'b1);
    step();
    idle_inputs(); asi_ready = 1; asi_result = 32'h1234_5678;
    step();
    asi_ready = 0; req_valid = 1;
    #1 chk("t1_rspv", rsp_valid, 1'b1);
    chk("t1_rsp", rsp_result, 32'h1234_5678);
    // Consumer stalls three cycles; no new accept meanwhile.
    repeat (3) step();
    rsp_ready = 1; req_valid = 0;
    step();
    rsp_ready = 0;
    #1 chk("t2_idle", rsp_valid, 1'b0);

    // Delayed completion: operands stay stable for four cycles.
    req_valid = 1; req_uop = 7'h05; req_rs1 = 32'hA5A5_A5A5; req_rs2 = 32'h5A5A_5A5A;
    step();
    req_valid = 0; req_rs1 = '0; req_rs2 = '0;
    repeat (3) step();
    #1 chk("t3_rs1", asi_rs1, 32'hA5A5_A5A5);
    asi_ready = 1; asi_result = 32'hCAFE_F00D;
    step();
    asi_ready = 0; rsp_ready = 1;
    step();
    rsp_ready = 0;

    // Flush beats a concurrent request; the request goes in next cycle.
    flush_req = 1; flush_sub = 1; flush_data = 32'hDEAD_BEEF; req_valid = 1;
    step();
    flush_req = 0; flush_sub = 0; flush_data = '0;
    #1 chk("t4_sub", asi_flush_aessub, 1'b1);
    chk("t4_data", asi_flush_data, 32'hDEAD_BEEF);
    step();
    #1 chk("t4_accept", req_ready, 1'b1);
    step();
    req_valid = 0;

    // Kill on the second busy cycle.
    step();
    kill = 1;
    step();
    kill = 0;
    #1 chk("t5_kill", asi_valid, 1'b0);
    step();

    // Reset asserted while busy drops every output at once.
    req_valid = 1; req_uop = 7'h7F; req_rs1 = 32'hFFFF_FFFF;
    step();
    req_valid = 0;
    g_resetn = 0;
    model_reset();
    #1 chk("t5_rst", asi_valid, 1'b0);
    step();
    g_resetn = 1;

    // Unit never answers.
    req_valid = 1; req_rs2 = 32'h0BAD_0BAD;
    step();
    idle_inputs();
    n = 0;
    while (asi_valid && n < 110) begin
      step();
      n++;
    end
`ifdef FRV_ASI_SEQ_TIMEOUT_EN
    chk("t6_cycles", n, TIMEOUT);
    chk("t6_err", rsp_err, 1'b1);
    rsp_ready = 1;
    step();
`else
    chk("t6_cycles", n, 110);
    kill = 1;
    step();
`endif
    idle_inputs();

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
